// File: rtl/ps2_key_tx.sv
// PS/2 device-side keystroke transmitter: sends a make frame, optionally followed by
// 0xF0 and the break frame, as 11-bit odd-parity frames with a fixed inter-frame gap.
module ps2_key_tx #(
  parameter int HALF_PERIOD = 4,
  parameter int GAP_CYCLES  = 8
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_key_valid,
  input  logic [7:0] i_key_code,
  input  logic       i_break_en,
  output logic       o_ps_clk,
  output logic       o_ps_data,
  output logic       o_busy,
  output logic       o_done
);

  localparam logic [7:0] HP_LAST    = 8'(HALF_PERIOD - 1);
  localparam logic [7:0] GAP_LAST   = 8'(GAP_CYCLES - 1);
  localparam logic [7:0] BREAK_CODE = 8'hF0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BIT_HI,
    S_BIT_LO,
    S_GAP
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [7:0]  r_timer, w_timer_nxt;
  logic [3:0]  r_bit, w_bit_nxt;
  logic [1:0]  r_frame, w_frame_nxt;
  logic [7:0]  r_code, w_code_nxt;
  logic        r_brk, w_brk_nxt;
  logic        r_ps_clk, r_ps_data, r_busy, r_done;
  logic        w_done_nxt, w_data_nxt;
  logic [1:0]  w_last_frame;
  logic [7:0]  w_byte_nxt;
  logic [15:0] w_frame_vec;

  always_comb begin
    w_state_nxt  = r_state;
    w_timer_nxt  = r_timer;
    w_bit_nxt    = r_bit;
    w_frame_nxt  = r_frame;
    w_code_nxt   = r_code;
    w_brk_nxt    = r_brk;
    w_done_nxt   = 1'b0;
    w_last_frame = r_brk ? 2'd2 : 2'd0;

    case (r_state)
      S_IDLE: begin
        if (i_key_valid) begin
          w_state_nxt = S_BIT_HI;
          w_timer_nxt = 8'd0;
          w_bit_nxt   = 4'd0;
          w_frame_nxt = 2'd0;
          w_code_nxt  = i_key_code;
          w_brk_nxt   = i_break_en;
        end
      end
      S_BIT_HI: begin
        if (r_timer == HP_LAST) begin
          w_state_nxt = S_BIT_LO;
          w_timer_nxt = 8'd0;
        end else begin
          w_timer_nxt = r_timer + 8'd1;
        end
      end
      S_BIT_LO: begin
        if (r_timer == HP_LAST) begin
          w_timer_nxt = 8'd0;
          if (r_bit == 4'd10) begin
            w_state_nxt = S_GAP;
          end else begin
            w_state_nxt = S_BIT_HI;
            w_bit_nxt   = r_bit + 4'd1;
          end
        end else begin
          w_timer_nxt = r_timer + 8'd1;
        end
      end
      S_GAP: begin
        if (r_timer == GAP_LAST) begin
          w_timer_nxt = 8'd0;
          if (r_frame == w_last_frame) begin
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt = S_BIT_HI;
            w_bit_nxt   = 4'd0;
            w_frame_nxt = r_frame + 2'd1;
          end
        end else begin
          w_timer_nxt = r_timer + 8'd1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Line value is derived from next-state so the registered outputs line up with the state.
  always_comb begin
    w_byte_nxt  = (w_frame_nxt == 2'd1) ? BREAK_CODE : w_code_nxt;
    w_frame_vec = {5'b11111, 1'b1, ~^w_byte_nxt, w_byte_nxt, 1'b0};
    w_data_nxt  = 1'b1;
    if (w_state_nxt == S_BIT_HI || w_state_nxt == S_BIT_LO) begin
      w_data_nxt = w_frame_vec[w_bit_nxt];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_timer   <= 8'd0;
      r_bit     <= 4'd0;
      r_frame   <= 2'd0;
      r_code    <= 8'd0;
      r_brk     <= 1'b0;
      r_ps_clk  <= 1'b1;
      r_ps_data <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_timer   <= w_timer_nxt;
      r_bit     <= w_bit_nxt;
      r_frame   <= w_frame_nxt;
      r_code    <= w_code_nxt;
      r_brk     <= w_brk_nxt;
      r_ps_clk  <= (w_state_nxt != S_BIT_LO);
      r_ps_data <= w_data_nxt;
      r_busy    <= (w_state_nxt != S_IDLE);
      r_done    <= w_done_nxt;
    end
  end

  assign o_ps_clk  = r_ps_clk;
  assign o_ps_data = r_ps_data;
  assign o_busy    = r_busy;
  assign o_done    = r_done;

endmodule

// File: tb/tb_ps2_key_tx.sv
// Scoreboard bench for ps2_key_tx: three instances (HALF_PERIOD 4/1/255) each with a
// line receiver/monitor that pops expected frames and keystroke timing from queues.
module tb_ps2_key_tx;

  localparam int NL = 3;

  function automatic int laneHp(input int l);
    case (l)
      0: return 4;
      1: return 1;
      default: return 255;
    endcase
  endfunction

  function automatic int laneGap(input int l);
    case (l)
      0: return 8;
      1: return 1;
      default: return 3;
    endcase
  endfunction

  logic       clk;
  logic       rstN;
  logic       kv[NL];
  logic [7:0] kc[NL];
  logic       be[NL];
  logic       psClk[NL];
  logic       psData[NL];
  logic       busy[NL];
  logic       done[NL];

  int nTests;
  int nFails;

  logic [7:0] expBytes[NL][$];
  int         expBusy[NL][$];
  int         expFrames[NL][$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void checkOutput(input int lane, input string name, input int act, input int exp);
    nTests++;
    if (act != exp) begin
      nFails++;
      $display("[TB] FAIL lane%0d %s: got %0d, expected %0d", lane, name, act, exp);
    end
  endfunction

  function automatic void reportUnexpected(input int lane, input string name);
    nTests++;
    nFails++;
    $display("[TB] FAIL lane%0d %s: got an event, expected none", lane, name);
  endfunction

  // Reference model: a keystroke is a list of bytes, each an 11-bit frame of 2*HP-cycle bits.
  function automatic void pushModel(input int lane, input logic [7:0] code, input logic brk);
    int nf;
    nf = brk ? 3 : 1;
    expBytes[lane].push_back(code);
    if (brk) begin
      expBytes[lane].push_back(8'hF0);
      expBytes[lane].push_back(code);
    end
    expFrames[lane].push_back(nf);
    expBusy[lane].push_back(nf * (11 * 2 * laneHp(lane) + laneGap(lane)));
  endfunction

  for (genvar g = 0; g < NL; g++) begin : gLane
    localparam int HP  = laneHp(g);
    localparam int GAP = laneGap(g);

    ps2_key_tx #(
      .HALF_PERIOD(HP),
      .GAP_CYCLES (GAP)
    ) dut (
      .i_clk      (clk),
      .i_rst_n    (rstN),
      .i_key_valid(kv[g]),
      .i_key_code (kc[g]),
      .i_break_en (be[g]),
      .o_ps_clk   (psClk[g]),
      .o_ps_data  (psData[g]),
      .o_busy     (busy[g]),
      .o_done     (done[g])
    );

    initial begin
      int lowLen = 0;
      int bitIdx = 0;
      int idleCnt = 0;
      int busyCnt = 0;
      int framesThisKey = 0;
      logic prevClk = 1'b1;
      logic prevData = 1'b1;
      logic lowChanged = 1'b0;
      logic gapArmed = 1'b0;
      logic [10:0] bits = '0;
      logic [7:0] e;
      forever begin
        @(negedge clk);
        if (!rstN) begin
          lowLen = 0; bitIdx = 0; idleCnt = 0; busyCnt = 0; framesThisKey = 0;
          prevClk = 1'b1; prevData = 1'b1; lowChanged = 1'b0; gapArmed = 1'b0;
        end else begin
          if (psClk[g] == 1'b0) begin
            if (psData[g] != prevData) lowChanged = 1'b1;
            lowLen++;
          end
          if (prevClk == 1'b0 && psClk[g] == 1'b1) begin
            checkOutput(g, "lowPhaseLen", lowLen, HP);
            checkOutput(g, "dataStableLow", int'(lowChanged), 0);
            lowLen = 0;
            lowChanged = 1'b0;
            if (bitIdx == 0) gapArmed = 1'b1;
          end
          if (gapArmed && psClk[g] && psData[g]) idleCnt++;
          if (prevClk == 1'b1 && psClk[g] == 1'b0) begin
            bits[bitIdx] = psData[g];
            bitIdx++;
            if (bitIdx == 11) begin
              bitIdx = 0;
              framesThisKey++;
              checkOutput(g, "startBit", int'(bits[0]), 0);
              checkOutput(g, "stopBit", int'(bits[10]), 1);
              if (expBytes[g].size() == 0) begin
                reportUnexpected(g, "extraFrame");
              end else begin
                e = expBytes[g].pop_front();
                checkOutput(g, "frameByte", int'(bits[8:1]), int'(e));
                checkOutput(g, "parityBit", int'(bits[9]), ($countones(e) % 2 == 0) ? 1 : 0);
              end
            end
          end else if (psClk[g] && !psData[g] && prevData && bitIdx == 0) begin
            if (gapArmed) checkOutput(g, "gapLen", idleCnt, GAP);
            gapArmed = 1'b0;
            idleCnt = 0;
          end
          if (busy[g]) busyCnt++;
          if (done[g]) begin
            checkOutput(g, "busyLowAtDone", int'(busy[g]), 0);
            if (expBusy[g].size() == 0) begin
              reportUnexpected(g, "extraDone");
            end else begin
              checkOutput(g, "busyCycles", busyCnt, expBusy[g].pop_front());
              checkOutput(g, "framesPerKey", framesThisKey, expFrames[g].pop_front());
            end
            busyCnt = 0; framesThisKey = 0; gapArmed = 1'b0; idleCnt = 0;
          end
          prevClk = psClk[g];
          prevData = psData[g];
        end
      end
    end
  end

  task automatic applyStimulus(input int lane, input logic [7:0] code, input logic brk);
    @(negedge clk);
    kv[lane] = 1'b1;
    kc[lane] = code;
    be[lane] = brk;
    pushModel(lane, code, brk);
    @(negedge clk);
    kv[lane] = 1'b0;
    kc[lane] = 8'($urandom_range(0, 255));
    be[lane] = 1'($urandom_range(0, 1));
  endtask

  task automatic waitDone(input int lane, input int budget, input string name);
    int n;
    n = 0;
    while (done[lane] !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    nTests++;
    if (n >= budget) begin
      nFails++;
      $display("[TB] FAIL lane%0d %s: got no done within %0d cycles, expected a done pulse", lane, name, budget);
    end
    @(negedge clk);
  endtask

  task automatic checkResetOutputs(input string name);
    for (int l = 0; l < NL; l++) begin
      checkOutput(l, {name, "PsClk"}, int'(psClk[l]), 1);
      checkOutput(l, {name, "PsData"}, int'(psData[l]), 1);
      checkOutput(l, {name, "Busy"}, int'(busy[l]), 0);
      checkOutput(l, {name, "Done"}, int'(done[l]), 0);
    end
  endtask

  initial begin
    nTests = 0;
    nFails = 0;
    for (int l = 0; l < NL; l++) begin
      kv[l] = 1'b0;
      kc[l] = 8'h00;
      be[l] = 1'b0;
    end
    rstN = 1'b1;
    #1 rstN = 1'b0;
    #2 checkResetOutputs("reset");
    repeat (3) @(posedge clk);
    #2 rstN = 1'b1;

    applyStimulus(0, 8'h3E, 1'b0);
    waitDone(0, 200, "make3E");
    applyStimulus(0, 8'h79, 1'b1);
    waitDone(0, 500, "break79");

    // A request arriving mid-sequence must leave the 0x3E sequence untouched.
    applyStimulus(0, 8'h3E, 1'b1);
    repeat (120) @(negedge clk);
    kv[0] = 1'b1; kc[0] = 8'h55; be[0] = 1'b0;
    @(negedge clk);
    kv[0] = 1'b0;
    waitDone(0, 400, "ignoredRequest");

    @(negedge clk);
    kc[0] = 8'h55; be[0] = 1'b0; kv[0] = 1'b1;
    for (int k = 0; k < 4; k++) pushModel(0, 8'h55, 1'b0);
    for (int k = 0; k < 3; k++) begin
      waitDone(0, 200, "heldValid");
      checkOutput(0, "backToBackBusy", int'(busy[0]), 1);
      checkOutput(0, "backToBackStart", int'(psData[0]), 0);
    end
    kv[0] = 1'b0;
    waitDone(0, 200, "heldValidLast");

    applyStimulus(0, 8'h3E, 1'b0);
    repeat (42) @(negedge clk);
    #2 rstN = 1'b0;
    #1 checkResetOutputs("midFrameReset");
    for (int l = 0; l < NL; l++) begin
      expBytes[l].delete();
      expBusy[l].delete();
      expFrames[l].delete();
    end
    repeat (3) @(posedge clk);
    #2 rstN = 1'b1;
    repeat (10) @(negedge clk);
    checkOutput(0, "idleAfterReset", int'(busy[0]), 0);
    applyStimulus(0, 8'h3E, 1'b0);
    waitDone(0, 200, "afterReset");

    for (int k = 0; k < 8; k++) begin
      applyStimulus(0, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
      waitDone(0, 500, "random0");
    end
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
      waitDone(1, 200, "random1");
    end
    applyStimulus(2, 8'($urandom_range(0, 255)), 1'b1);
    waitDone(2, 18000, "slowLane");

    repeat (5) @(negedge clk);
    for (int l = 0; l < NL; l++) begin
      checkOutput(l, "pendingFrames", expBytes[l].size(), 0);
      checkOutput(l, "pendingDones", expBusy[l].size(), 0);
    end

    $display("[TB] %0d tests run, %0d failed", nTests, nFails);
    $finish;
  end

endmodule

// File: doc/ps2_key_tx.md
PS2_KEY_TX -- requirements
Module: ps2_key_tx

Interface
REQ-001 Parameter HALF_PERIOD, default 4: number of clk cycles in each ps_clk high phase and each ps_clk low phase; legal range 1-255.
REQ-002 Parameter GAP_CYCLES, default 8: number of idle clk cycles between consecutive frames of one keystroke; legal range 1-255.
REQ-003 clk  input  1  system clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low; 0 = reset.
REQ-005 key_valid  input  1  keystroke request strobe, sampled every clk.
REQ-006 key_code  input  8  scan code, captured with key_valid.
REQ-007 break_en  input  1  captured with key_valid; 1 = make + break sequence, 0 = make frame only.
REQ-008 ps_clk  output  1  PS/2 clock line driven by the device.
REQ-009 ps_data  output  1  PS/2 data line driven by the device.
REQ-010 busy  output  1  high from accept until the keystroke sequence completes.
REQ-011 done  output  1  one-cycle pulse when the keystroke sequence completes.

Function
REQ-012 Line protocol:
- Idle state is ps_clk=1, ps_data=1.
- A frame is 11 bits: bit0 start=0; bits1-8 the data byte, LSB first; bit9 odd parity; bit10 stop=1.
- Odd parity: parity bit = 1 when the data byte has an even number of ones.
REQ-013 Per-bit timing:
- ps_data changes only at the start of the bit's ps_clk-high phase.
- The high phase lasts HALF_PERIOD cycles, then the low phase lasts HALF_PERIOD cycles.
- A host samples ps_data on the falling edge of ps_clk.
REQ-014 State machine:
- IDLE -> BIT_HI on accept.
- BIT_HI -> BIT_LO after HALF_PERIOD cycles.
- BIT_LO -> BIT_HI (next bit) after HALF_PERIOD cycles if bit < 10.
- BIT_LO -> GAP after bit 10.
- GAP -> BIT_HI (next frame) after GAP_CYCLES cycles if frames remain; otherwise GAP -> IDLE with done=1.
REQ-015 Accept condition is key_valid=1 in IDLE:
- key_code and break_en are latched.
- busy rises on the next cycle.
- ps_data=0 (start bit, ps_clk=1) appears on the next cycle.
REQ-016 key_valid while busy=1 is ignored entirely; latched data is not disturbed.
REQ-017 Frame sequence:
- break_en=1: key_code, then 0xF0, then key_code (3 frames).
- break_en=0: key_code only (1 frame).
REQ-018 During GAP, ps_clk=1 and ps_data=1.
REQ-019 The final frame is followed by GAP_CYCLES idle cycles before completion. The last GAP cycle transitions to IDLE; on the following cycle busy=0 and done=1 for exactly one cycle.
REQ-020 key_valid=1 on the same cycle done=1 is accepted, because the state is IDLE. A new sequence may therefore start back-to-back.
REQ-021 Frame duration is 22*HALF_PERIOD cycles. Total busy time is:
- break_en=1: 3*(22*HALF_PERIOD + GAP_CYCLES) cycles.
- break_en=0: 22*HALF_PERIOD + GAP_CYCLES cycles.
REQ-022 Counters are sized for their maximum value (bit index 0-10, frame index 0-2, 8-bit timer) and never wrap in legal operation.
REQ-023 All outputs are registered, with no combinational path from inputs to outputs.

Reset
REQ-024 rst=0 immediately forces ps_clk=1, ps_data=1, busy=0, done=0, state IDLE, and all counters and latched data to 0, independent of clk.
REQ-025 rst asserted mid-frame aborts the sequence without completing the frame or pulsing done. After release the block idles until a new key_valid.
REQ-026 First accept possible on the first clk edge after rst deasserts.

Verification
REQ-027 HALF_PERIOD=4, GAP=8, key_code=0x3E, break_en=0, one-cycle key_valid:
- bits on falling edges = 0,0,1,1,1,1,1,0,0,0(parity),1.
- busy for 96 cycles.
- one done pulse.
REQ-028 key_code=0x79, break_en=1:
- three frames decoded by a bench receiver as 0x79, 0xF0, 0x79.
- parity bits 0, 1, 0.
- gaps of exactly 8 idle cycles.
- done once.
REQ-029 key_valid pulsed with 0x55 during the second frame of a 0x3E break sequence: ignored; output remains 0x3E, 0xF0, 0x3E.
REQ-030 key_valid held high continuously with 0x55, break_en=0: a new frame starts on the cycle after each done pulse, with no missing or extra frames.
REQ-031 rst pulsed low during bit 5 of a frame:
- outputs return to 1/1/0/0 asynchronously.
- no done pulse.
- next keystroke transmitted correctly.
REQ-032 Bench checker: ps_data never changes while ps_clk=0, and every low phase is exactly HALF_PERIOD cycles (HALF_PERIOD=1 and 255 corners).
